gray_rx_check: RTL and testbench

Receive-side counterpart to the free-running Gray-code counter. Samples a Gray-coded count stream and converts it to binary. Checks that each new sample is a legal single-step successor (+1 mod 2^CBITS) of the previous one and tracks lock state. Sits at the consumer end of a Gray-coded counter link, for example a pointer or timestamp crossing into this clock domain.

---
 rtl/gray_rx_check.sv | 113 +++++++++++
 tb/tb_gray_rx_check.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_rx_check.sv
// Gray-coded count receiver: decodes each sample to binary, checks it is a hold
// or a single +1 step from the previous sample, and tracks acquisition/lock.
module gray_rx_check #(
    parameter int CBITS  = 10,
    parameter int LOCK_N = 4,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [CBITS-1:0] gray_in,
    output logic             out_valid,
    output logic [CBITS-1:0] bin_out,
    output logic             step_err,
    output logic             hold,
    output logic             wrap,
    output logic             zero,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       o_dbg_state,
    output logic [3:0]       o_dbg_good_cnt
);

    // Handshake: in_valid qualifies gray_in for one cycle; every valid sample is
    // accepted (no ready), and out_valid pulses exactly one cycle later.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [CBITS-1:0] REF_MAX  = '1;
    localparam logic [3:0]       LOCK_CNT = 4'(LOCK_N);

    state_t           r_state;
    logic [CBITS-1:0] r_ref;
    logic [3:0]       r_good_cnt;

    logic [CBITS-1:0] w_bin;
    logic [CBITS-1:0] w_next;
    logic [3:0]       w_good_inc;
    logic             w_is_hold;
    logic             w_is_good;

    always_comb begin
        w_bin = '0;
        w_bin[CBITS-1] = gray_in[CBITS-1];
        for (int i = CBITS - 2; i >= 0; i--) begin
            w_bin[i] = w_bin[i+1] ^ gray_in[i];
        end
    end

    assign w_next      = r_ref + CBITS'(1);
    assign w_good_inc  = r_good_cnt + 4'd1;
    assign w_is_hold   = (w_bin == r_ref);
    assign w_is_good   = (w_bin == w_next);
    assign o_dbg_state    = r_state;
    assign o_dbg_good_cnt = r_good_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ref      <= '0;
            r_good_cnt <= '0;
            out_valid  <= 1'b0;
            bin_out    <= '0;
            step_err   <= 1'b0;
            hold       <= 1'b0;
            wrap       <= 1'b0;
            zero       <= 1'b0;
            locked     <= 1'b0;
            err_cnt    <= '0;
        end else begin
            out_valid <= in_valid;
            step_err  <= 1'b0;
            hold      <= 1'b0;
            wrap      <= 1'b0;
            zero      <= 1'b0;
            if (in_valid) begin
                bin_out <= w_bin;
                zero    <= (w_bin == '0);
                // Reference follows every sample, errors included, so we resync.
                r_ref   <= w_bin;
                if (r_state == S_IDLE) begin
                    r_good_cnt <= '0;
                    r_state    <= S_ACQ;
                end else if (w_is_hold) begin
                    hold <= 1'b1;
                end else if (w_is_good) begin
                    wrap <= (r_ref == REF_MAX);
                    if (r_state == S_ACQ) begin
                        r_good_cnt <= w_good_inc;
                        if (w_good_inc == LOCK_CNT) begin
                            r_state <= S_LOCKED;
                            locked  <= 1'b1;
                        end
                    end
                end else begin
                    step_err   <= 1'b1;
                    r_good_cnt <= '0;
                    r_state    <= S_ACQ;
                    locked     <= 1'b0;
                    if (err_cnt != ERR_MAX) begin
                        err_cnt <= err_cnt + ERR_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gray_rx_check.sv
// Bench for gray_rx_check: a reference model predicts each output beat into a
// queue; a monitor pops and compares; scenario tasks add inline spot checks.
module tb_gray_rx_check;

    localparam int CBITS   = 10;
    localparam int LOCK_N  = 4;
    localparam int ERR_W   = 8;
    localparam int ERR_SAT = (1 << ERR_W) - 1;
    localparam int EW      = CBITS + 5 + ERR_W;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [CBITS-1:0] gray_in;
    logic             out_valid;
    logic [CBITS-1:0] bin_out;
    logic             step_err;
    logic             hold;
    logic             wrap;
    logic             zero;
    logic             locked;
    logic [ERR_W-1:0] err_cnt;
    logic [1:0]       o_dbg_state;
    logic [3:0]       o_dbg_good_cnt;

    int checks   = 0;
    int failures = 0;

    logic [EW-1:0] exp_q[$];

    // Reference model state: 0 idle, 1 acquiring, 2 locked
    int               m_state;
    logic [CBITS-1:0] m_ref;
    int               m_good;
    int               m_err;

    gray_rx_check #(.CBITS(CBITS), .LOCK_N(LOCK_N), .ERR_W(ERR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .gray_in        (gray_in),
        .out_valid      (out_valid),
        .bin_out        (bin_out),
        .step_err       (step_err),
        .hold           (hold),
        .wrap           (wrap),
        .zero           (zero),
        .locked         (locked),
        .err_cnt        (err_cnt),
        .o_dbg_state    (o_dbg_state),
        .o_dbg_good_cnt (o_dbg_good_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        gray_in  = '0;
    end

    task automatic model_reset();
        m_state = 0;
        m_ref   = '0;
        m_good  = 0;
        m_err   = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Driver: present binary value b as Gray, predict the output beat.
    task automatic send(input logic [CBITS-1:0] b);
        logic [CBITS-1:0] nxt;
        logic             se, ho, wr;
        @(negedge clk);
        in_valid = 1'b1;
        gray_in  = b ^ (b >> 1);
        se = 1'b0;
        ho = 1'b0;
        wr = 1'b0;
        if (m_state == 0) begin
            m_good  = 0;
            m_state = 1;
        end else begin
            nxt = m_ref + 1'b1;
            if (b == m_ref) begin
                ho = 1'b1;
            end else if (b == nxt) begin
                wr = (m_ref == {CBITS{1'b1}});
                if (m_state == 1) begin
                    m_good++;
                    if (m_good == LOCK_N) m_state = 2;
                end
            end else begin
                se      = 1'b1;
                m_good  = 0;
                m_state = 1;
                if (m_err < ERR_SAT) m_err++;
            end
        end
        m_ref = b;
        exp_q.push_back({b, se, ho, wr, (b == '0), (m_state == 2), ERR_W'(m_err)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            gray_in  = CBITS'($urandom_range(0, (1 << CBITS) - 1));
        end
    endtask

    // Scoreboard monitor: sampled 2 time units after each rising edge
    always @(posedge clk) begin
        logic [EW-1:0] exp_v;
        logic [EW-1:0] act_v;
        #2;
        if (out_valid === 1'b1 || exp_q.size() != 0) begin
            checks++;
            act_v = {bin_out, step_err, hold, wrap, zero, locked, err_cnt};
            if (out_valid !== 1'b1) begin
                failures++;
                $display("FAIL out_valid_missing: got %b expected 1", out_valid);
                void'(exp_q.pop_front());
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_valid_extra: got out_valid=1 with no sample pending");
            end else begin
                exp_v = exp_q.pop_front();
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL beat: got bin=%0d se=%b ho=%b wr=%b z=%b lk=%b ec=%0d expected bin=%0d se=%b ho=%b wr=%b z=%b lk=%b ec=%0d",
                             bin_out, step_err, hold, wrap, zero, locked, err_cnt,
                             exp_v[EW-1 -: CBITS], exp_v[ERR_W+4], exp_v[ERR_W+3],
                             exp_v[ERR_W+2], exp_v[ERR_W+1], exp_v[ERR_W], exp_v[ERR_W-1:0]);
                end
            end
        end
    end

    task automatic test_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        gray_in  = 10'h155;
        model_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if ({out_valid, bin_out, step_err, hold, wrap, zero, locked, err_cnt,
             o_dbg_state, o_dbg_good_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_state: got ov=%b bin=%0d se=%b ho=%b wr=%b z=%b lk=%b ec=%0d st=%0d gc=%0d expected all 0",
                     out_valid, bin_out, step_err, hold, wrap, zero, locked, err_cnt,
                     o_dbg_state, o_dbg_good_cnt);
        end
        send(10'd7);
        idle(1);
        checks++;
        if (o_dbg_state !== 2'd1) begin
            failures++;
            $display("FAIL idle_load_state: got %0d expected 1", o_dbg_state);
        end
    endtask

    task automatic test_count_up();
        do_reset();
        for (int v = 0; v <= 5; v++) send(CBITS'(v));
        idle(1);
        checks++;
        if (locked !== 1'b1 || o_dbg_state !== 2'd2) begin
            failures++;
            $display("FAIL lock_after_steps: got locked=%b state=%0d expected 1 2", locked, o_dbg_state);
        end
    endtask

    task automatic test_wrap();
        for (int v = 1018; v <= 1023; v++) send(CBITS'(v));
        send(10'd0);
        idle(1);
        checks++;
        if (wrap !== 1'b1 || zero !== 1'b1 || locked !== 1'b1 || step_err !== 1'b0) begin
            failures++;
            $display("FAIL wrap_step: got wrap=%b zero=%b locked=%b se=%b expected 1 1 1 0",
                     wrap, zero, locked, step_err);
        end
    endtask

    task automatic test_step_error();
        do_reset();
        for (int v = 0; v <= 5; v++) send(CBITS'(v));
        send(10'd10);
        idle(1);
        checks++;
        if (step_err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0 || bin_out !== 10'd10) begin
            failures++;
            $display("FAIL step_err_unlock: got se=%b ec=%0d locked=%b bin=%0d expected 1 1 0 10",
                     step_err, err_cnt, locked, bin_out);
        end
        send(10'd11);
        idle(1);
        checks++;
        if (o_dbg_good_cnt !== 4'd1 || step_err !== 1'b0) begin
            failures++;
            $display("FAIL resync_good: got gc=%0d se=%b expected 1 0", o_dbg_good_cnt, step_err);
        end
    endtask

    task automatic test_hold_idle();
        send(10'd4);
        send(10'd4);
        idle(1);
        checks++;
        if (hold !== 1'b1 || step_err !== 1'b0 || o_dbg_good_cnt !== 4'(m_good)) begin
            failures++;
            $display("FAIL hold_sample: got ho=%b se=%b gc=%0d expected 1 0 %0d",
                     hold, step_err, o_dbg_good_cnt, m_good);
        end
        for (int i = 0; i < 3; i++) begin
            idle(1);
            checks++;
            if (out_valid !== 1'b0 || bin_out !== 10'd4 || hold !== 1'b0 || zero !== 1'b0) begin
                failures++;
                $display("FAIL idle_hold_%0d: got ov=%b bin=%0d ho=%b z=%b expected 0 4 0 0",
                         i, out_valid, bin_out, hold, zero);
            end
        end
    endtask

    task automatic test_err_saturate();
        for (int i = 0; i < 260; i++) send((i % 2) ? 10'd10 : 10'd0);
        idle(1);
        checks++;
        if (err_cnt !== 8'd255) begin
            failures++;
            $display("FAIL err_saturate: got %0d expected 255", err_cnt);
        end
        send(10'd0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        gray_in  = 10'h00F;
        model_reset();
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (err_cnt !== '0 || locked !== 1'b0 || o_dbg_state !== 2'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_stream: got ec=%0d locked=%b state=%0d ov=%b expected 0 0 0 0",
                     err_cnt, locked, o_dbg_state, out_valid);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_count_up();
        test_wrap();
        test_step_error();
        test_hold_idle();
        test_err_saturate();
        idle(3);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending beats expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
